// File: rtl/wb_walk_initiator.sv
// ---------------------------------------------------------------------------
// wb_walk_initiator
//
// Wishbone pipelined-mode master for the LED-walker slave. A start request
// launches a walk with a single write of START_DATA, then the slave is polled
// with reads spaced POLL_INTERVAL idle cycles apart until it reports an idle
// walker state (read data bits [3:0] == 0). Completion, the number of
// non-idle polls and a sticky timeout flag are reported to local logic.
//
// Parameters:
//   POLL_INTERVAL  idle cycles (o_cyc low) between transactions, >= 1
//   TIMEOUT        cycles from strobe assertion to ack before abort, >= 2
//   START_DATA     write data for the launching write
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_request                start pulse, honoured only while idle
//   o_busy                   sequence in progress (through the done cycle)
//   o_done                   one-cycle end-of-sequence pulse
//   o_err                    sticky timeout flag, cleared by the next start
//   o_polls                  non-idle poll reads in the last sequence (sat.)
//   o_cyc, o_stb, o_we       Wishbone master control
//   o_addr, o_data           Wishbone address (always 0) and write data
//   i_stall, i_ack, i_data   Wishbone slave responses
// ---------------------------------------------------------------------------
module wb_walk_initiator #(
    parameter int unsigned POLL_INTERVAL = 16,
    parameter int unsigned TIMEOUT       = 1023,
    parameter logic [31:0] START_DATA    = 32'h0000_0001
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_request,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_polls,
    output logic        o_cyc,
    output logic        o_stb,
    output logic        o_we,
    output logic        o_addr,
    output logic [31:0] o_data,
    input  logic        i_stall,
    input  logic        i_ack,
    input  logic [31:0] i_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_WAIT,
        S_GAP,
        S_RD_REQ,
        S_RD_WAIT,
        S_DONE
    } state_t;

    // The timeout counter never has to hold more than TIMEOUT-1, and the
    // gap counter never more than POLL_INTERVAL-1.
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_INTERVAL - 1);

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [15:0]        polls_q, polls_d;
    logic               err_q, err_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [31:0]        data_q, data_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic in_req;
    logic in_wait;
    logic is_read;
    logic complete;
    logic tmo_hit;

    // Only the walker state nibble of the read data carries information.
    logic unused_data_bits;
    assign unused_data_bits = ^i_data[31:4];

    assign in_req   = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
    assign in_wait  = (state_q == S_WR_WAIT) || (state_q == S_RD_WAIT);
    assign is_read  = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
    // An ack only counts once the strobe has been accepted, which may be in
    // the very cycle the strobe is taken.
    assign complete = i_ack && (in_wait || (in_req && !i_stall));
    // Counter holds the number of bus cycles already spent, so the last
    // permitted cycle of a transaction is the one where it equals TIMEOUT-1.
    assign tmo_hit  = (in_req || in_wait) && (tmo_q == TMO_LAST);

    // State register: all flops, including the registered bus outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            gap_q   <= '0;
            polls_q <= '0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            polls_q <= polls_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            data_q  <= data_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic. An ack that coincides with the timeout cycle wins,
    // so completion is tested before the abort.
    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        gap_d   = '0;
        polls_d = polls_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (i_request) begin
                    state_d = S_WR_REQ;
                    polls_d = '0;
                    err_d   = 1'b0;
                end
            end

            S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (complete) begin
                    tmo_d = '0;
                    if (!is_read) begin
                        state_d = S_GAP;
                    end else if (i_data[3:0] == 4'h0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GAP;
                        if (polls_q != 16'hFFFF) begin
                            polls_d = polls_q + 16'd1;
                        end
                    end
                end else if (tmo_hit) begin
                    tmo_d   = '0;
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else if (in_req && !i_stall) begin
                    state_d = (state_q == S_WR_REQ) ? S_WR_WAIT : S_RD_WAIT;
                end
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_RD_REQ;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so every output is a flop that
    // changes on the same edge as the state it belongs to.
    always_comb begin
        cyc_d  = (state_d == S_WR_REQ) || (state_d == S_WR_WAIT) ||
                 (state_d == S_RD_REQ) || (state_d == S_RD_WAIT);
        stb_d  = (state_d == S_WR_REQ) || (state_d == S_RD_REQ);
        we_d   = (state_d == S_WR_REQ) || (state_d == S_WR_WAIT);
        data_d = we_d ? START_DATA : 32'h0;
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_err   = err_q;
    assign o_polls = polls_q;
    assign o_cyc   = cyc_q;
    assign o_stb   = stb_q;
    assign o_we    = we_q;
    assign o_addr  = 1'b0;
    assign o_data  = data_q;

endmodule

// File: tb/tb_wb_walk_initiator.sv
// ---------------------------------------------------------------------------
// tb_wb_walk_initiator
//
// Directed bench for wb_walk_initiator. A behavioural walker slave answers
// the bus with a configurable stall count, ack latency and a list of walker
// states to return, while recording what it sees on the bus. A table of
// scenarios is run in a loop, followed by hand-written sequences for the
// timeout, stray request/ack and reset-during-read cases.
// ---------------------------------------------------------------------------
module tb_wb_walk_initiator;

    localparam int          POLL  = 16;
    localparam int          TMO   = 1023;
    localparam logic [31:0] START = 32'h0000_0001;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_request;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [15:0] o_polls;
    logic        o_cyc;
    logic        o_stb;
    logic        o_we;
    logic        o_addr;
    logic [31:0] o_data;
    logic        i_stall;
    logic        i_ack;
    logic [31:0] i_data;

    // Scenario record: slave behaviour followed by the expected outcome.
    // Latencies count cycles after the strobe is accepted; -1 means never.
    typedef struct {
        int          wr_stall;
        int          wr_lat;
        int          rd_lat;
        int          nrd;
        logic [15:0] rd_vals;
        int          exp_writes;
        int          exp_reads;
        int          exp_polls;
        int          exp_err;
        int          exp_gaps;
        int          exp_wr_stb;
        int          exp_last_len;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    // Slave configuration, written by the main process only.
    int          cfg_wr_stall = 0;
    int          cfg_wr_lat   = 1;
    int          cfg_rd_lat   = 1;
    int          cfg_nrd      = 0;
    logic [15:0] cfg_rd_vals  = 16'h0;
    logic        spurious     = 1'b0;

    // Observations, written by the slave process only.
    int          n_wr = 0, n_rd = 0, n_done = 0, n_gaps = 0, n_gap_bad = 0;
    int          n_unstable = 0, n_rd_bad = 0;
    int          last_cyc_len = 0, last_stb_len = 0, wr_stb_len = 0;
    logic [31:0] wr_data = 32'h0;

    // Snapshots taken at the start of each sequence.
    int s_wr, s_rd, s_done, s_gaps, s_gap_bad, s_unstable, s_rd_bad;
    int found;

    wb_walk_initiator #(
        .POLL_INTERVAL (POLL),
        .TIMEOUT       (TMO),
        .START_DATA    (START)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_request (i_request),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err),
        .o_polls   (o_polls),
        .o_cyc     (o_cyc),
        .o_stb     (o_stb),
        .o_we      (o_we),
        .o_addr    (o_addr),
        .o_data    (o_data),
        .i_stall   (i_stall),
        .i_ack     (i_ack),
        .i_data    (i_data)
    );

    always #5 i_clk = ~i_clk;

    // Walker slave model: samples the bus on the falling edge and drives its
    // response for the next rising edge.
    initial begin : slave
        logic        active;
        logic        acked;
        logic        we0;
        logic [31:0] d0;
        logic [3:0]  nib;
        int          k, stall_left, lat, acc_k, stb_cycles;
        int          low_run, seq_txn, rd_idx;
        active = 1'b0; acked = 1'b0; we0 = 1'b0; d0 = 32'h0; nib = 4'h0;
        k = 0; stall_left = 0; lat = 0; acc_k = -1; stb_cycles = 0;
        low_run = 0; seq_txn = 0; rd_idx = 0;
        i_ack = 1'b0; i_stall = 1'b0; i_data = 32'h0;
        forever begin
            @(negedge i_clk);
            i_ack   = 1'b0;
            i_stall = 1'b0;
            i_data  = 32'h0;
            if (o_done === 1'b1) n_done++;
            if (o_busy !== 1'b1) begin
                low_run = 0;
                seq_txn = 0;
                rd_idx  = 0;
            end
            if (o_cyc !== 1'b1) begin
                if (active) begin
                    last_cyc_len = k + 1;
                    last_stb_len = stb_cycles;
                    if (we0) wr_stb_len = stb_cycles;
                    active = 1'b0;
                end
                if (o_busy === 1'b1) low_run++;
                if (spurious) begin
                    i_ack  = 1'b1;
                    i_data = {28'hABCDEF1, 4'h0};
                end
            end else begin
                if (!active) begin
                    active     = 1'b1;
                    k          = 0;
                    we0        = o_we;
                    d0         = o_data;
                    stb_cycles = 0;
                    acc_k      = -1;
                    acked      = 1'b0;
                    stall_left = (o_we === 1'b1) ? cfg_wr_stall : 0;
                    lat        = (o_we === 1'b1) ? cfg_wr_lat : cfg_rd_lat;
                    if (seq_txn > 0) begin
                        n_gaps++;
                        if (low_run != POLL) n_gap_bad++;
                    end
                    seq_txn++;
                    low_run = 0;
                end else begin
                    k++;
                end
                if (o_stb === 1'b1) begin
                    stb_cycles++;
                    if (o_we !== we0 || o_data !== d0) n_unstable++;
                    if (o_we !== 1'b1 && o_data !== 32'h0) n_rd_bad++;
                    if (stall_left > 0) begin
                        i_stall = 1'b1;
                        stall_left--;
                    end else begin
                        acc_k = k;
                        if (o_we === 1'b1) begin
                            n_wr++;
                            wr_data = o_data;
                        end else begin
                            n_rd++;
                        end
                    end
                end
                if (acc_k >= 0 && !acked && lat >= 0 && k == acc_k + lat) begin
                    i_ack = 1'b1;
                    acked = 1'b1;
                    nib   = 4'h0;
                    if (!we0) begin
                        if (rd_idx < cfg_nrd) nib = cfg_rd_vals[4*rd_idx +: 4];
                        rd_idx++;
                    end
                    i_data = {28'hABCDEF1, nib};
                end
            end
        end
    end

    // Global guard so a stuck design still ends the run.
    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next falling edge, clear of the active edge.
    task automatic step();
        @(negedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkReset(input string name);
        checkOutput($sformatf("%s_ctl", name),
                    {25'h0, o_cyc, o_stb, o_we, o_addr, o_done, o_err, o_busy}, 32'h0);
        checkOutput($sformatf("%s_data", name), o_data, 32'h0);
        checkOutput($sformatf("%s_polls", name), {16'h0, o_polls}, 32'h0);
    endtask

    // Load the slave behaviour, snapshot the counters and pulse a start.
    task automatic applyStimulus(input vec_t v);
        cfg_wr_stall = v.wr_stall;
        cfg_wr_lat   = v.wr_lat;
        cfg_rd_lat   = v.rd_lat;
        cfg_nrd      = v.nrd;
        cfg_rd_vals  = v.rd_vals;
        s_wr       = n_wr;
        s_rd       = n_rd;
        s_done     = n_done;
        s_gaps     = n_gaps;
        s_gap_bad  = n_gap_bad;
        s_unstable = n_unstable;
        s_rd_bad   = n_rd_bad;
        i_request  = 1'b1;
        step();
        i_request  = 1'b0;
    endtask

    // Wait (bounded) for the done pulse, then compare the whole outcome.
    task automatic finishCheck(input vec_t v, input string tag);
        int i;
        i = 0;
        while (n_done == s_done && i < 4000) begin
            step();
            i++;
        end
        checkOutput($sformatf("%s_done_seen", tag), (n_done != s_done), 1);
        checkOutput($sformatf("%s_busy_in_done", tag), o_busy, 1);
        repeat (3) step();
        checkOutput($sformatf("%s_done_pulses", tag), n_done - s_done, 1);
        checkOutput($sformatf("%s_busy_after", tag), o_busy, 0);
        checkOutput($sformatf("%s_err", tag), o_err, v.exp_err);
        checkOutput($sformatf("%s_polls", tag), o_polls, v.exp_polls);
        checkOutput($sformatf("%s_writes", tag), n_wr - s_wr, v.exp_writes);
        if (v.exp_writes > 0) checkOutput($sformatf("%s_wr_data", tag), wr_data, START);
        checkOutput($sformatf("%s_reads", tag), n_rd - s_rd, v.exp_reads);
        checkOutput($sformatf("%s_gaps", tag), n_gaps - s_gaps, v.exp_gaps);
        checkOutput($sformatf("%s_gap_len_bad", tag), n_gap_bad - s_gap_bad, 0);
        checkOutput($sformatf("%s_stb_unstable", tag), n_unstable - s_unstable, 0);
        checkOutput($sformatf("%s_rd_bus_bad", tag), n_rd_bad - s_rd_bad, 0);
        checkOutput($sformatf("%s_wr_stb_len", tag), wr_stb_len, v.exp_wr_stb);
        checkOutput($sformatf("%s_last_cyc_len", tag), last_cyc_len, v.exp_last_len);
    endtask

    initial begin : main
        vec_t vecs[7];
        vec_t v;
        i_reset   = 1'b1;
        i_request = 1'b0;

        // wr_stall, wr_lat, rd_lat, nrd, rd_vals (nibble 0 first),
        // writes, reads, polls, err, gaps, wr_stb, last_len
        vecs[0] = '{0, 1,    1, 3, 16'h0035, 1, 3, 2, 0, 3, 1, 2};
        vecs[1] = '{7, 1,    1, 1, 16'h0000, 1, 1, 0, 0, 1, 8, 2};
        vecs[2] = '{0, 0,    0, 2, 16'h0002, 1, 2, 1, 0, 2, 1, 1};
        vecs[3] = '{3, 0,    0, 2, 16'h0009, 1, 2, 1, 0, 2, 4, 1};
        vecs[4] = '{0, 1022, 1, 1, 16'h0000, 1, 1, 0, 0, 1, 1, 2};
        vecs[5] = '{0, 1023, 1, 1, 16'h0000, 1, 0, 0, 1, 0, 1, 1023};
        vecs[6] = '{0, 2,    2, 4, 16'h0321, 1, 4, 3, 0, 4, 1, 3};

        repeat (3) step();
        checkReset("reset_init");
        i_reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            finishCheck(vecs[i], $sformatf("vec%0d", i));
        end

        // Write stalled forever: strobe held until the timeout aborts it.
        v = '{5000, 1, 1, 0, 16'h0000, 0, 0, 0, 1, 0, 1023, 1023};
        applyStimulus(v);
        checkOutput("tmo_polls_cleared", o_polls, 0);
        finishCheck(v, "tmo_stall");

        // Next start clears the error; a request and a stray ack during the
        // gap must not disturb the sequence.
        applyStimulus(vecs[0]);
        checkOutput("errclr_err", o_err, 0);
        checkOutput("errclr_busy", o_busy, 1);
        repeat (3) step();
        i_request = 1'b1;
        spurious  = 1'b1;
        step();
        i_request = 1'b0;
        spurious  = 1'b0;
        finishCheck(vecs[0], "busy_req");

        // Reset while the second read is waiting for its ack.
        v = vecs[0];
        v.rd_lat = 40;
        applyStimulus(v);
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            if (n_rd - s_rd == 2 && o_cyc === 1'b1 && o_stb === 1'b0) found = 1;
            else step();
        end
        checkOutput("rst_rdwait_reached", found, 1);
        checkOutput("rst_polls_before", o_polls, 1);
        i_reset = 1'b1;
        step();
        checkReset("rst_mid");
        i_reset = 1'b0;
        step();
        applyStimulus(vecs[0]);
        finishCheck(vecs[0], "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_walk_initiator.md
Name: wb_walk_initiator

Overview:
Wishbone pipelined-mode bus master that drives the LED-walker slave. On a start request it issues one write to launch a walk, then polls the slave with reads at a fixed interval until the returned state reads idle. It reports completion, poll count and bus errors to local logic, such as a button debouncer or a status display. It is the initiator end of the walker's single-word Wishbone interface.

Parameters:
POLL_INTERVAL, 16, idle cycles with o_cyc low between the end of one bus transaction and the next read (min 1)
TIMEOUT, 1023, cycles from o_stb assertion to i_ack before the transaction is aborted (min 2)
START_DATA, 32'h0000_0001, value driven on o_data for the launching write

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_request  in  1  start pulse; sampled only in IDLE
o_busy  out  1  high from the cycle after an accepted request through the DONE cycle
o_done  out  1  one-cycle pulse when the sequence ends, on success or error
o_err  out  1  sticky timeout flag; cleared when the next request is accepted
o_polls  out  16  number of reads returning non-idle in the last sequence, saturating at 16'hFFFF
o_cyc  out  1  Wishbone cycle
o_stb  out  1  Wishbone strobe
o_we  out  1  Wishbone write enable
o_addr  out  1  Wishbone address, always 0
o_data  out  32  Wishbone write data
i_stall  in  1  slave stall
i_ack  in  1  slave acknowledge
i_data  in  32  slave read data; only bits [3:0] (walker state) are used

Behaviour:
- Reset: all outputs 0 (o_cyc, o_stb, o_we, o_done, o_err, o_busy, o_addr, o_data, o_polls). FSM goes to IDLE and the timeout and gap counters clear. Reset mid-transaction drops o_cyc/o_stb at the next edge, with no handshake completion.
- States: IDLE, WR_REQ, WR_WAIT, GAP, RD_REQ, RD_WAIT, DONE.
- IDLE: on i_request go to WR_REQ. Next cycle: o_cyc=o_stb=o_we=1, o_data=START_DATA, o_polls=0, o_err=0. i_request in any other state is ignored.
- *_REQ: o_stb is held, with o_we, o_addr and o_data stable, while i_stall=1. When o_stb && !i_stall, o_stb drops at the next edge and the FSM moves to *_WAIT with o_cyc still high.
- *_WAIT: on i_ack, o_cyc drops at the next edge.
  - After a write ack, go to GAP.
  - After a read ack: if i_data[3:0]==0, go to DONE. Otherwise o_polls+=1 (saturating) and go to GAP.
- Ack in the accept cycle: if i_ack arrives in the same cycle as o_stb && !i_stall, it completes the transaction. o_stb and o_cyc both drop at the next edge and the FSM proceeds as from *_WAIT.
- i_ack while o_cyc=0 is ignored. At most one request is outstanding at a time.
- GAP: o_cyc=0 for exactly POLL_INTERVAL cycles, then RD_REQ with o_we=0 and o_data=0.
- Timeout: the counter resets when o_stb rises and increments every cycle in *_REQ and *_WAIT, stall cycles included.
  - If it reaches TIMEOUT with no ack: drop o_cyc and o_stb at the next edge, set o_err=1 and go to DONE.
  - An ack arriving in the same cycle as the timeout wins: it counts as success.
- DONE: lasts one cycle. o_done=1, o_busy stays 1, then return to IDLE (o_busy=0).
- o_busy=1 in every state except IDLE, registered.
- o_addr is always 0 (the address bit is reserved).
- The launching write may stall if the slave is still mid-walk. This is legal and is bounded only by TIMEOUT.

Test Plan:
- Nominal: slave model with no stall, 1-cycle ack, and read data 5,3,0 -> exactly 1 write carrying 32'h1, 3 reads, o_polls=2, o_done pulses once, o_err=0, o_cyc low for exactly 16 cycles between transactions.
- Stall: i_stall=1 for 7 cycles on the write -> o_stb, o_we and o_data held constant for all 8 strobe cycles, a single ack is accepted, no duplicate request.
- Timeout: slave never acks -> o_cyc/o_stb drop exactly 1023 cycles after o_stb rose, o_err=1, o_done pulses; the next i_request clears o_err.
- Same-cycle accept and ack, plus an ack landing on the timeout cycle -> transaction completes as success, with no extra wait cycle.
- Request while busy, and a spurious i_ack with o_cyc=0 -> both ignored, o_polls unchanged, sequence unaffected.
- Reset asserted during RD_WAIT -> next cycle all outputs are 0 and the FSM is IDLE; a fresh i_request then runs the full sequence normally.
